// File: rtl/mat_pkg.sv
// Shared constants, FSM state encoding and element packing helper for the
// time-multiplexed 4x4 matrix multiplier.
package mat_pkg;

    localparam int MAT_N  = 4;
    localparam int ELEM_W = 16;
    localparam int BUS_W  = MAT_N * MAT_N * ELEM_W;
    localparam int PROD_W = 2 * ELEM_W;
    localparam int ACC_W  = PROD_W + 2;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Bit offset of element [row][col] on the bus: ELEM_W*(MAT_N*row+col).
    function automatic logic [7:0] idx(input logic [1:0] row, input logic [1:0] col);
        idx = {row, col, 4'b0000};
    endfunction

endpackage

// File: rtl/mat_mul_sequencer_if.sv
// Operand/result bus of the matrix multiplier: operand beat and result
// handshakes plus status flags.
interface mat_mul_sequencer_if;
    import mat_pkg::*;

    logic [BUS_W-1:0] dataInBus;
    logic             inValid;
    logic             inReady;
    logic [BUS_W-1:0] dataOut;
    logic             outValid;
    logic             outReady;
    logic             busy;
    logic             overflow;

    modport master (
        output dataInBus, inValid, outReady,
        input  inReady, dataOut, outValid, busy, overflow
    );

    modport slave (
        input  dataInBus, inValid, outReady,
        output inReady, dataOut, outValid, busy, overflow
    );

endinterface

// File: rtl/mac_unit.sv
// Shared multiply-accumulate: 16x16 product added to a registered 34-bit
// accumulator; 'first' restarts the sum from zero for a new dot product.
module mac_unit
    import mat_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic              first,
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic [ACC_W-1:0]  sum
);

    logic [PROD_W-1:0] prod_s;
    logic [ACC_W-1:0]  base_s;
    logic [ACC_W-1:0]  acc_r;

    // Product and running sum; 'sum' is the value the accumulator takes this edge.
    always_comb begin
        prod_s = {{(PROD_W-ELEM_W){1'b0}}, a} * {{(PROD_W-ELEM_W){1'b0}}, b};
        base_s = first ? {ACC_W{1'b0}} : acc_r;
        sum    = base_s + {{(ACC_W-PROD_W){1'b0}}, prod_s};
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (clear) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (enable) begin
            acc_r <= sum;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/mat_mul_sequencer.sv
// Sequential 4x4 matrix multiplier: loads A then B over one bus, runs 64 MAC
// steps through a single mac_unit and holds the packed result until taken.
module mat_mul_sequencer
    import mat_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    mat_mul_sequencer_if.slave bus
);

    state_t           state_r;
    state_t           stateNext_s;
    logic [BUS_W-1:0] aMat_r;
    logic [BUS_W-1:0] bMat_r;
    logic [BUS_W-1:0] cMat_r;
    logic [5:0]       step_r;
    logic [1:0]       iIdx_s;
    logic [1:0]       jIdx_s;
    logic [1:0]       kIdx_s;
    logic             loadA_s;
    logic             loadB_s;
    logic             compute_s;
    logic             overflow_r;
    logic             outValid_r;
    logic             busy_r;
    logic [ACC_W-1:0] sum_s;
    logic [ELEM_W-1:0] aElem_s;
    logic [ELEM_W-1:0] bElem_s;

    // Step counter is {i, j, k}: k runs fastest, i slowest.
    assign iIdx_s  = step_r[5:4];
    assign jIdx_s  = step_r[3:2];
    assign kIdx_s  = step_r[1:0];
    assign aElem_s = aMat_r[idx(iIdx_s, kIdx_s) +: ELEM_W];
    assign bElem_s = bMat_r[idx(kIdx_s, jIdx_s) +: ELEM_W];

    assign bus.inReady  = (state_r == LOAD_A) || (state_r == LOAD_B);
    assign bus.outValid = outValid_r;
    assign bus.busy     = busy_r;
    assign bus.overflow = overflow_r;
    assign bus.dataOut  = cMat_r;

    mac_unit u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (loadB_s),
        .enable (compute_s),
        .first  (kIdx_s == 2'd0),
        .a      (aElem_s),
        .b      (bElem_s),
        .sum    (sum_s)
    );

    // Next-state and load/compute strobes.
    always_comb begin
        stateNext_s = state_r;
        loadA_s     = 1'b0;
        loadB_s     = 1'b0;
        compute_s   = 1'b0;
        case (state_r)
            LOAD_A: begin
                if (bus.inValid) begin
                    loadA_s     = 1'b1;
                    stateNext_s = LOAD_B;
                end else begin
                    stateNext_s = LOAD_A;
                end
            end
            LOAD_B: begin
                if (bus.inValid) begin
                    loadB_s     = 1'b1;
                    stateNext_s = COMPUTE;
                end else begin
                    stateNext_s = LOAD_B;
                end
            end
            COMPUTE: begin
                compute_s = 1'b1;
                if (step_r == 6'd63) begin
                    stateNext_s = DONE;
                end else begin
                    stateNext_s = COMPUTE;
                end
            end
            DONE: begin
                if (bus.outReady) begin
                    stateNext_s = LOAD_A;
                end else begin
                    stateNext_s = DONE;
                end
            end
            default: begin
                stateNext_s = LOAD_A;
            end
        endcase
    end

    // State register with status flags registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= LOAD_A;
            busy_r     <= 1'b0;
            outValid_r <= 1'b0;
        end else begin
            state_r    <= stateNext_s;
            busy_r     <= (stateNext_s == COMPUTE);
            outValid_r <= (stateNext_s == DONE);
        end
    end

    // Operand latches, step counter, result registers and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            aMat_r     <= {BUS_W{1'b0}};
            bMat_r     <= {BUS_W{1'b0}};
            cMat_r     <= {BUS_W{1'b0}};
            step_r     <= 6'd0;
            overflow_r <= 1'b0;
        end else if (loadA_s) begin
            aMat_r     <= bus.dataInBus;
            cMat_r     <= {BUS_W{1'b0}};
            overflow_r <= 1'b0;
        end else if (loadB_s) begin
            bMat_r <= bus.dataInBus;
            step_r <= 6'd0;
        end else if (compute_s) begin
            step_r <= step_r + 6'd1;
            // The k==3 sum is the finished dot product for C[i][j].
            if (kIdx_s == 2'd3) begin
                cMat_r[idx(iIdx_s, jIdx_s) +: ELEM_W] <= sum_s[ELEM_W-1:0];
                overflow_r <= overflow_r | (|sum_s[ACC_W-1:ELEM_W]);
            end else begin
                overflow_r <= overflow_r;
            end
        end else begin
            step_r <= step_r;
        end
    end

endmodule

// File: tb/tb_mat_mul_sequencer.sv
// Directed and random checks of mat_mul_sequencer against a software matrix
// model, with a scoreboard of expected results.
module tb_mat_mul_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [255:0] c;
        logic         ovf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mat_mul_sequencer_if bus();

    mat_mul_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] packM(input int unsigned v[16]);
        logic [255:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) r[16*n +: 16] = v[n][15:0];
        return r;
    endfunction

    function automatic void model(input logic [255:0] a, input logic [255:0] b,
                                  output logic [255:0] c, output logic ovf);
        longint s;
        c   = '0;
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++)
                    s += longint'(a[16*(4*i+k) +: 16]) * longint'(b[16*(4*k+j) +: 16]);
                c[16*(4*i+j) +: 16] = s[15:0];
                if (s >= 65536) ovf = 1'b1;
            end
        end
    endfunction

    // Drives one operand beat and returns just after the accepting edge.
    task automatic sendBeat(input logic [255:0] d);
        int w = 0;
        bus.dataInBus = d;
        bus.inValid   = 1'b1;
        while (!bus.inReady && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("acceptTimeout", 256'(w < 100), 256'(1));
        @(posedge clk);
        #1;
        bus.inValid = 1'b0;
    endtask

    task automatic runJob(input logic [255:0] a, input logic [255:0] b,
                          input int gapA, input int gapB, input int stall,
                          output logic [255:0] obsC, output logic obsOvf);
        exp_t e;
        int   lat;
        int   busyCnt;
        model(a, b, e.c, e.ovf);
        bus.outReady = (stall == 0);
        repeat (gapA) @(negedge clk);
        sendBeat(a);
        repeat (gapB) @(negedge clk);
        sendBeat(b);
        sb.push_back(e);
        lat     = 0;
        busyCnt = 0;
        @(negedge clk);
        while (!bus.outValid && lat < 200) begin
            if (bus.busy) busyCnt++;
            @(negedge clk);
            lat++;
        end
        check("latency", 256'(lat), 256'(64));
        check("busyCycles", 256'(busyCnt), 256'(64));
        check("busyInDone", 256'(bus.busy), 256'(0));
        for (int s = 0; s < stall; s++) begin
            bus.inValid   = 1'b1;
            bus.dataInBus = {8{$urandom}};
            check("stallData", bus.dataOut, sb[0].c);
            check("stallInReady", 256'(bus.inReady), 256'(0));
            check("stallOutValid", 256'(bus.outValid), 256'(1));
            @(negedge clk);
        end
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
        e = sb.pop_front();
        obsC   = bus.dataOut;
        obsOvf = bus.overflow;
        check("resultData", bus.dataOut, e.c);
        check("resultOverflow", 256'(bus.overflow), 256'(e.ovf));
        @(posedge clk);
        #1;
        check("outValidDrop", 256'(bus.outValid), 256'(0));
        check("inReadyRise", 256'(bus.inReady), 256'(1));
        @(negedge clk);
    endtask

    initial begin
        int unsigned  tv[16];
        logic [255:0] refA, refB, refC, ovfA, idA, rA, rB, obsC;
        logic         refOvf, obsOvf;

        bus.dataInBus = '0;
        bus.inValid   = 1'b0;
        bus.outReady  = 1'b0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rstInReady", 256'(bus.inReady), 256'(1));
        check("rstOutValid", 256'(bus.outValid), 256'(0));
        check("rstBusy", 256'(bus.busy), 256'(0));
        check("rstOverflow", 256'(bus.overflow), 256'(0));
        check("rstDataOut", bus.dataOut, 256'd0);
        reset = 1'b0;
        @(negedge clk);

        // Reference job.
        tv   = '{5, 8, 9, 2, 7, 3, 8, 4, 6, 5, 4, 3, 8, 5, 7, 6};
        refA = packM(tv);
        tv   = '{11, 14, 19, 18, 6, 9, 3, 5, 12, 10, 15, 14, 1, 3, 5, 7};
        refB = packM(tv);
        model(refA, refB, refC, refOvf);
        runJob(refA, refB, 0, 0, 0, obsC, obsOvf);
        check("refC00", 256'(obsC[15:0]), 256'(213));
        check("refC01", 256'(obsC[31:16]), 256'(238));
        check("refC33", 256'(obsC[255:240]), 256'(309));
        check("refOvf", 256'(obsOvf), 256'(0));

        // Backpressure for 20 cycles with ignored beats.
        runJob(refA, refB, 0, 0, 20, obsC, obsOvf);
        check("bpResult", obsC, refC);

        // Overflow then identity x B.
        ovfA = {16{16'h0100}};
        runJob(ovfA, ovfA, 0, 0, 0, obsC, obsOvf);
        check("ovfData", obsC, 256'd0);
        check("ovfFlag", 256'(obsOvf), 256'(1));
        tv  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        idA = packM(tv);
        runJob(idA, refB, 0, 0, 0, obsC, obsOvf);
        check("identData", obsC, refB);
        check("identOvf", 256'(obsOvf), 256'(0));

        // Reset 30 cycles into COMPUTE.
        sendBeat(refA);
        sendBeat(refB);
        repeat (30) @(negedge clk);
        check("midBusy", 256'(bus.busy), 256'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abortOutValid", 256'(bus.outValid), 256'(0));
        check("abortBusy", 256'(bus.busy), 256'(0));
        check("abortDataOut", bus.dataOut, 256'd0);
        check("abortInReady", 256'(bus.inReady), 256'(1));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        runJob(refA, refB, 0, 0, 0, obsC, obsOvf);
        check("afterAbort", obsC, refC);

        // Gapped input.
        runJob(refA, refB, 3, 5, 0, obsC, obsOvf);
        check("gapped", obsC, refC);

        // Random jobs with random stalls.
        for (int n = 0; n < 10; n++) begin
            for (int e = 0; e < 16; e++)
                tv[e] = (n < 5) ? $urandom_range(0, 255) : ($urandom & 32'h0000_FFFF);
            rA = packM(tv);
            for (int e = 0; e < 16; e++)
                tv[e] = (n < 5) ? $urandom_range(0, 255) : ($urandom & 32'h0000_FFFF);
            rB = packM(tv);
            runJob(rA, rB, $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 4), obsC, obsOvf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
